// File: rtl/calcn_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : calcn_pkg                                                       |
// | Purpose  : Shared command/response encodings and width helpers for the     |
// |            calcn multi-port calculator engine.                             |
// | Contents : cmd_e, resp_e, CMD_W, RESP_W, calcn_shamt_w(), calcn_idx_w()    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package calcn_pkg;

    localparam int CMD_W  = 4;
    localparam int RESP_W = 2;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [RESP_W-1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2,
        RESP_SAT  = 2'd3
    } resp_e;

    // Number of operand2 bits that form the shift amount.
    function automatic int calcn_shamt_w(input int data_w);
        return $clog2(data_w);
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int calcn_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/calcn_port_fifo.sv
// +----------------------------------------------------------------------------+
// | Module   : calcn_port_fifo                                                 |
// | Purpose  : Per-port request capture (command+operand1, then operand2) and  |
// |            in-order request FIFO feeding the shared arbiter.               |
// | Ports    : clk_i, rst_ni      clock / async active-low reset               |
// |            cmd_i, data_i      port command and operand bus                 |
// |            pop_i              arbiter grant: drop head entry               |
// |            valid_o            FIFO non-empty                               |
// |            cmd_o/op1_o/op2_o  head entry                                   |
// |            busy_o             registered FIFO-full flag                    |
// |            ovr_o              sticky: command seen while busy              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module calcn_port_fifo
    import calcn_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [CMD_W-1:0]  cmd_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [CMD_W-1:0]  cmd_o,
    output logic [DATA_W-1:0] op1_o,
    output logic [DATA_W-1:0] op2_o,
    output logic              busy_o,
    output logic              ovr_o
);

    localparam int               PTR_W    = calcn_idx_w(FIFO_DEPTH);
    localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [CMD_W-1:0]  cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } req_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OP2  = 1'b1
    } state_e;

    state_e            state_q;
    logic [CMD_W-1:0]  cmd_hold_q;
    logic [DATA_W-1:0] op1_hold_q;
    logic              ovr_q;
    logic              busy_q;

    req_t              mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    logic              w_push;
    logic              w_pop;
    req_t              w_head;

    // Operand2 arrives in the cycle after the command; the entry is complete
    // exactly when the capture FSM sits in ST_OP2.
    assign w_push = (state_q == ST_OP2);
    assign w_pop  = pop_i && (count_q != '0);

    // Capture FSM. A command is only accepted from ST_IDLE; the command bus
    // during the operand2 cycle is don't-care. Admission uses the registered
    // full flag, so a pop in the same cycle does not make room yet.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cmd_hold_q <= '0;
            op1_hold_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_i != CMD_NOP) begin
                        if (busy_q) begin
                            ovr_q <= 1'b1;
                        end else begin
                            state_q    <= ST_OP2;
                            cmd_hold_q <= cmd_i;
                            op1_hold_q <= data_i;
                        end
                    end
                end
                ST_OP2:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            busy_q   <= (count_d == CNT_FULL);
        end
    end

    // Storage needs no reset: entries are only read while count_q is nonzero.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {cmd_hold_q, op1_hold_q, data_i};
        end
    end

    assign w_head  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign cmd_o   = w_head.cmd;
    assign op1_o   = w_head.op1;
    assign op2_o   = w_head.op2;
    assign busy_o  = busy_q;
    assign ovr_o   = ovr_q;

endmodule

`default_nettype wire

// File: rtl/calcn.sv
// +----------------------------------------------------------------------------+
// | Module   : calcn                                                           |
// | Purpose  : NUM_PORTS-port calculator. Each port queues two-cycle requests  |
// |            in its own FIFO; a round-robin arbiter feeds one shared         |
// |            registered ALU (add, sub, shl, shr).                            |
// | Ports    : c_clk, reset_n         clock / async active-low reset           |
// |            req_cmd_in            4-bit command per port                    |
// |            req_data_in           operand per port                          |
// |            out_data, out_resp    one-cycle result/response per port       |
// |            out_busy              port FIFO full                            |
// |            ovr_err               sticky command-while-busy flag            |
// |            Port i uses slice [i*W +: W] of every packed bus.              |
// | Config   : CALCN_SAT_EN - saturate add overflow / sub underflow (resp 3)   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module calcn
    import calcn_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        c_clk,
    input  logic                        reset_n,
    input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS*RESP_W-1:0] out_resp,
    output logic [NUM_PORTS-1:0]        out_busy,
    output logic [NUM_PORTS-1:0]        ovr_err
);

    localparam int                SHAMT_W   = calcn_shamt_w(DATA_W);
    localparam int                PORT_W    = calcn_idx_w(NUM_PORTS);
    localparam logic [PORT_W-1:0] PORT_LAST = PORT_W'(NUM_PORTS - 1);
    localparam logic [PORT_W:0]   NP_EXT    = (PORT_W + 1)'(NUM_PORTS);

    logic [NUM_PORTS-1:0] w_valid;
    logic [CMD_W-1:0]     w_cmd [NUM_PORTS];
    logic [DATA_W-1:0]    w_op1 [NUM_PORTS];
    logic [DATA_W-1:0]    w_op2 [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_gnt_oh;

    generate
        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            calcn_port_fifo #(
                .DATA_W     (DATA_W),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk_i   (c_clk),
                .rst_ni  (reset_n),
                .cmd_i   (req_cmd_in[p*CMD_W +: CMD_W]),
                .data_i  (req_data_in[p*DATA_W +: DATA_W]),
                .pop_i   (w_gnt_oh[p]),
                .valid_o (w_valid[p]),
                .cmd_o   (w_cmd[p]),
                .op1_o   (w_op1[p]),
                .op2_o   (w_op2[p]),
                .busy_o  (out_busy[p]),
                .ovr_o   (ovr_err[p])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan from ptr_q upward with wrap; the first
    // non-empty FIFO wins and the pointer moves just past it.
    // ------------------------------------------------------------------
    logic [PORT_W-1:0] ptr_q, ptr_d;
    logic [PORT_W-1:0] w_gnt_idx;
    logic              w_gnt_any;
    logic [PORT_W:0]   w_cand;

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_cand = {1'b0, ptr_q} + (PORT_W + 1)'(k);
            if (w_cand >= NP_EXT) begin
                w_cand = w_cand - NP_EXT;
            end
            if (!w_gnt_any && w_valid[w_cand[PORT_W-1:0]]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand[PORT_W-1:0];
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_gnt_oh[p] = w_gnt_any && (w_gnt_idx == PORT_W'(p));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (w_gnt_any) begin
            ptr_d = (w_gnt_idx == PORT_LAST) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // ALU on the granted head entry
    // ------------------------------------------------------------------
    logic [CMD_W-1:0]  w_sel_cmd;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res_data;
    logic [RESP_W-1:0] w_res_resp;

    assign w_sel_cmd = w_cmd[w_gnt_idx];
    assign w_a       = w_op1[w_gnt_idx];
    assign w_b       = w_op2[w_gnt_idx];

    // Anything not explicitly handled (including invalid codes) reports
    // an error with zero data.
    always_comb begin
        w_sum      = {1'b0, w_a} + {1'b0, w_b};
        w_res_data = '0;
        w_res_resp = RESP_ERR;
        case (w_sel_cmd)
            CMD_ADD: begin
                if (!w_sum[DATA_W]) begin
                    w_res_data = w_sum[DATA_W-1:0];
                    w_res_resp = RESP_OK;
                end
`ifdef CALCN_SAT_EN
                else begin
                    w_res_data = '1;
                    w_res_resp = RESP_SAT;
                end
`endif
            end
            CMD_SUB: begin
                if (w_b <= w_a) begin
                    w_res_data = w_a - w_b;
                    w_res_resp = RESP_OK;
                end
`ifdef CALCN_SAT_EN
                else begin
                    w_res_data = '0;
                    w_res_resp = RESP_SAT;
                end
`endif
            end
            CMD_SHL: begin
                w_res_data = w_a << w_b[SHAMT_W-1:0];
                w_res_resp = RESP_OK;
            end
            CMD_SHR: begin
                w_res_data = w_a >> w_b[SHAMT_W-1:0];
                w_res_resp = RESP_OK;
            end
            default: begin
                w_res_data = '0;
                w_res_resp = RESP_ERR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered outputs: only the granted port's slice is nonzero, and
    // only for the single cycle after its grant.
    // ------------------------------------------------------------------
    logic [NUM_PORTS*DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_PORTS*RESP_W-1:0] out_resp_q, out_resp_d;

    always_comb begin
        out_data_d = '0;
        out_resp_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_gnt_oh[p]) begin
                out_data_d[p*DATA_W +: DATA_W] = w_res_data;
                out_resp_d[p*RESP_W +: RESP_W] = w_res_resp;
            end
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q      <= '0;
            out_data_q <= '0;
            out_resp_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            out_data_q <= out_data_d;
            out_resp_q <= out_resp_d;
        end
    end

    assign out_data = out_data_q;
    assign out_resp = out_resp_q;

endmodule

`default_nettype wire
